// File: rtl/load_check_gen.sv
// Load drive and current-sense checker: energises a load from a latched command,
// waits for it to settle, debounces the sense comparator and pulses one result class.
module load_check_gen #(
  parameter int SETTLE_CYCLES   = 50000,
  parameter int DEBOUNCE_CYCLES = 500,
  parameter int TIMEOUT_CYCLES  = 25000
) (
  input  logic clk_50MHz,
  input  logic rst,
  input  logic cmd_on,
  input  logic check_req,
  input  logic sense_in,
  output logic drive_out,
  output logic busy,
  output logic result_on,
  output logic result_off,
  output logic result_err,
  output logic result_open
);

  localparam int MAXP = (SETTLE_CYCLES > DEBOUNCE_CYCLES)
                        ? ((SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES)
                        : ((DEBOUNCE_CYCLES > TIMEOUT_CYCLES) ? DEBOUNCE_CYCLES : TIMEOUT_CYCLES);
  localparam int CW = $clog2(MAXP + 1);

  localparam logic [CW-1:0] CNT_MAX     = '1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(TIMEOUT_CYCLES - 1);

  // One-hot result vector, ordered {on, off, err, open}
  localparam logic [3:0] RES_ON   = 4'b1000;
  localparam logic [3:0] RES_OFF  = 4'b0100;
  localparam logic [3:0] RES_ERR  = 4'b0010;
  localparam logic [3:0] RES_OPEN = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_DEBOUNCE,
    S_REPORT
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic            r_sync1;
  logic            r_senseS;
  logic            r_cmdLat;
  logic            w_cmdLat;
  logic            r_ref;
  logic            w_ref;
  logic [CW-1:0]   r_settleCnt;
  logic [CW-1:0]   w_settleCnt;
  logic [CW-1:0]   r_stableCnt;
  logic [CW-1:0]   w_stableCnt;
  logic [CW-1:0]   r_timeoutCnt;
  logic [CW-1:0]   w_timeoutCnt;
  logic [3:0]      r_result;
  logic [3:0]      w_result;
  logic            w_stableHit;

  function automatic logic [CW-1:0] satInc(input logic [CW-1:0] x);
    return (x == CNT_MAX) ? x : x + 1'b1;
  endfunction

  function automatic logic [3:0] decode(input logic cmd, input logic sense);
    logic [3:0] res;
    case ({cmd, sense})
      2'b11:   res = RES_ON;
      2'b00:   res = RES_OFF;
      2'b10:   res = RES_OPEN;
      default: res = RES_ERR;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sync1      <= 1'b0;
      r_senseS     <= 1'b0;
      r_cmdLat     <= 1'b0;
      r_ref        <= 1'b0;
      r_settleCnt  <= '0;
      r_stableCnt  <= '0;
      r_timeoutCnt <= '0;
      r_result     <= '0;
    end else begin
      r_state      <= w_nextState;
      r_sync1      <= sense_in;
      r_senseS     <= r_sync1;
      r_cmdLat     <= w_cmdLat;
      r_ref        <= w_ref;
      r_settleCnt  <= w_settleCnt;
      r_stableCnt  <= w_stableCnt;
      r_timeoutCnt <= w_timeoutCnt;
      r_result     <= w_result;
    end
  end

  // Result is loaded on the edge entering REPORT, so the pulse coincides with that state
  always_comb begin
    w_nextState  = r_state;
    w_cmdLat     = r_cmdLat;
    w_ref        = r_ref;
    w_settleCnt  = r_settleCnt;
    w_stableCnt  = r_stableCnt;
    w_timeoutCnt = r_timeoutCnt;
    w_result     = '0;
    w_stableHit  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (check_req) begin
          w_cmdLat    = cmd_on;
          w_settleCnt = '0;
          w_nextState = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_settleCnt == SETTLE_LAST) begin
          w_stableCnt  = '0;
          w_timeoutCnt = '0;
          w_ref        = r_senseS;
          w_nextState  = S_DEBOUNCE;
        end else begin
          w_settleCnt = satInc(r_settleCnt);
        end
      end
      S_DEBOUNCE: begin
        w_timeoutCnt = satInc(r_timeoutCnt);
        if (r_senseS == r_ref) begin
          if (r_stableCnt == DEB_LAST) begin
            w_stableHit = 1'b1;
          end else begin
            w_stableCnt = satInc(r_stableCnt);
          end
        end else begin
          w_ref       = r_senseS;
          w_stableCnt = '0;
        end
        if (w_stableHit) begin
          w_result    = decode(r_cmdLat, r_ref);
          w_nextState = S_REPORT;
        end else if (r_timeoutCnt == TMO_LAST) begin
          w_result    = RES_ERR;
          w_nextState = S_REPORT;
        end
      end
      S_REPORT: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  assign drive_out = r_cmdLat;
  assign busy      = (r_state != S_IDLE);
  assign {result_on, result_off, result_err, result_open} = r_result;

endmodule

// File: tb/tb_load_check_gen.sv
// Directed bench for load_check_gen: expected results are queued when a check is
// started and compared by a monitor when the DUT pulses a result.
module tb_load_check_gen;

  localparam int SETTLE   = 8;
  localparam int DEBOUNCE = 4;
  localparam int TIMEOUT  = 32;
  localparam int LAT_NORMAL = SETTLE + DEBOUNCE + 1;
  localparam int LAT_TMO    = SETTLE + TIMEOUT + 1;

  localparam logic [3:0] V_ON   = 4'b1000;
  localparam logic [3:0] V_OFF  = 4'b0100;
  localparam logic [3:0] V_ERR  = 4'b0010;
  localparam logic [3:0] V_OPEN = 4'b0001;

  typedef struct {
    logic [3:0] vec;
    int         lat;
    logic       drv;
  } exp_t;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic cmdOn    = 1'b0;
  logic checkReq = 1'b0;
  logic senseIn  = 1'b0;
  logic driveOut;
  logic busy;
  logic resOn, resOff, resErr, resOpen;
  logic [3:0] resVec;

  exp_t sbQ[$];
  exp_t eMon;
  int   total    = 0;
  int   bad      = 0;
  int   pulses   = 0;
  int   busyCnt  = 0;
  bit   prevPulse = 1'b0;

  load_check_gen #(
    .SETTLE_CYCLES  (SETTLE),
    .DEBOUNCE_CYCLES(DEBOUNCE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk_50MHz  (clk),
    .rst        (rst),
    .cmd_on     (cmdOn),
    .check_req  (checkReq),
    .sense_in   (senseIn),
    .drive_out  (driveOut),
    .busy       (busy),
    .result_on  (resOn),
    .result_off (resOff),
    .result_err (resErr),
    .result_open(resOpen)
  );

  assign resVec = {resOn, resOff, resErr, resOpen};

  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic expectResult(input logic [3:0] vec, input int lat, input logic drv);
    sbQ.push_back('{vec: vec, lat: lat, drv: drv});
  endtask

  // Pulses check_req for one cycle; returns at the falling edge just after the accept edge
  task automatic applyStimulus(input logic cmd);
    @(negedge clk);
    cmdOn    = cmd;
    checkReq = 1'b1;
    @(negedge clk);
    checkReq = 1'b0;
    checkOutput("busyAfterAccept", busy, 1);
    checkOutput("driveAfterAccept", driveOut, cmd);
  endtask

  task automatic waitPulse(input int budget, input bit toggle);
    int start = pulses;
    int n = 0;
    while (pulses == start && n < budget) begin
      @(negedge clk);
      #1;
      n++;
      if (toggle && (n % 2 == 0)) senseIn = ~senseIn;
    end
    checkOutput("pulseArrived", pulses - start, 1);
  endtask

  // Busy cycles are counted from the accept edge; the pulse must land on the last one
  always @(negedge clk) begin
    if (!rst) begin
      busyCnt = busy ? busyCnt + 1 : 0;
      if (prevPulse) begin
        checkOutput("pulseWidth", resVec, 4'b0000);
        checkOutput("busyAfterReport", busy, 0);
      end
      prevPulse = 1'b0;
      if (resVec !== 4'b0000) begin
        pulses++;
        prevPulse = 1'b1;
        checkOutput("sbHasEntry", sbQ.size() > 0, 1);
        if (sbQ.size() > 0) begin
          eMon = sbQ.pop_front();
          checkOutput("resultClass", resVec, eMon.vec);
          checkOutput("latency", busyCnt, eMon.lat);
          checkOutput("driveAtResult", driveOut, eMon.drv);
        end
      end
    end
  end

  logic [3:0] tblVec [3];
  logic       tblCmd [3];
  logic       tblSense [3];
  int         p0;

  initial begin
    tblCmd[0] = 1'b0; tblSense[0] = 1'b0; tblVec[0] = V_OFF;
    tblCmd[1] = 1'b1; tblSense[1] = 1'b0; tblVec[1] = V_OPEN;
    tblCmd[2] = 1'b0; tblSense[2] = 1'b1; tblVec[2] = V_ERR;

    repeat (3) @(negedge clk);
    checkOutput("resetDrive", driveOut, 0);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetResults", resVec, 4'b0000);
    rst = 1'b0;

    $display("[TB] on check, steady current");
    senseIn = 1'b1;
    repeat (3) @(negedge clk);
    expectResult(V_ON, LAT_NORMAL, 1'b1);
    applyStimulus(1'b1);
    waitPulse(60, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("driveHoldsOn", driveOut, 1);

    $display("[TB] decode table");
    for (int i = 0; i < 3; i++) begin
      senseIn = tblSense[i];
      repeat (3) @(negedge clk);
      expectResult(tblVec[i], LAT_NORMAL, tblCmd[i]);
      applyStimulus(tblCmd[i]);
      waitPulse(60, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("driveHoldsCmd", driveOut, tblCmd[i]);
    end

    $display("[TB] unstable sense, timeout");
    senseIn = 1'b1;
    repeat (3) @(negedge clk);
    expectResult(V_ERR, LAT_TMO, 1'b1);
    applyStimulus(1'b1);
    waitPulse(80, 1'b1);

    // Sense drops for one cycle just as the stable count is about to complete;
    // debounce restarts twice (drop, then recovery), pushing the pulse out by 5 cycles
    $display("[TB] single glitch in debounce");
    senseIn = 1'b1;
    repeat (4) @(negedge clk);
    expectResult(V_ON, LAT_NORMAL + 5, 1'b1);
    applyStimulus(1'b1);
    repeat (9) @(negedge clk);
    senseIn = 1'b0;
    @(negedge clk);
    senseIn = 1'b1;
    waitPulse(60, 1'b0);

    $display("[TB] request and command change while busy");
    senseIn = 1'b0;
    repeat (4) @(negedge clk);
    expectResult(V_OFF, LAT_NORMAL, 1'b0);
    applyStimulus(1'b0);
    repeat (4) @(negedge clk);
    checkReq = 1'b1;
    cmdOn    = 1'b1;
    @(negedge clk);
    checkReq = 1'b0;
    cmdOn    = 1'b0;
    checkOutput("driveIgnoresCmd", driveOut, 0);
    checkOutput("busyDuringIgnore", busy, 1);
    waitPulse(60, 1'b0);

    $display("[TB] reset mid-check");
    senseIn = 1'b1;
    repeat (4) @(negedge clk);
    p0 = pulses;
    applyStimulus(1'b1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("driveAfterAbort", driveOut, 0);
    checkOutput("busyAfterAbort", busy, 0);
    checkOutput("resultsAfterAbort", resVec, 4'b0000);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("noPulseAfterAbort", pulses - p0, 0);
    expectResult(V_ON, LAT_NORMAL, 1'b1);
    applyStimulus(1'b1);
    waitPulse(60, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("sbDrained", sbQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
